// File: rtl/chip_data_deser_pkg.sv
// chip_data_deser_pkg: shared sizing defaults and FSM state encoding for the chip-side link deserialiser
package chip_data_deser_pkg;
  localparam int BIT_CHIP = 6;
  localparam int NODE = 16;
  localparam int N = BIT_CHIP * NODE;
  localparam int CNT_W = $clog2(N + 2);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
endpackage

// File: rtl/chip_data_deser_sync.sv
// sig_sync_edge: sync_len-deep synchroniser with rising-edge detect on the synchronised level
module sig_sync_edge #(
  parameter int sync_len = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [sync_len-1:0] sync;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[sync_len-2:0], d};
      prev <= lvl;
    end
  end
  assign lvl = sync[sync_len-1];
  assign rise = lvl & ~prev;
endmodule

// File: rtl/chip_data_deser.sv
// chip_data_deser: recovers bit_chip*node-bit frames from the oversampled data/clk/latch serial link
module chip_data_deser
  import chip_data_deser_pkg::*;
#(
  parameter int bit_chip = BIT_CHIP,
  parameter int node = NODE,
  parameter int sync_len = 2,
  parameter int cnt_w = 8
) (
  input  logic                       clk_main,
  input  logic                       rst,
  input  logic                       clk_data_de2,
  input  logic                       data_to_chip,
  input  logic                       latch,
  output logic [bit_chip*node-1:0]   array_out,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [cnt_w-1:0]           frame_count
);
  localparam int n = bit_chip * node;
  localparam int bw = $clog2(n + 2);
  logic clk_lvl, clk_rise, latch_lvl, latch_rise, data_lvl, data_rise;
  logic [n-1:0] shift_reg;
  logic [bw-1:0] bit_cnt, cnt_next;
  logic [1:0] state, state_next;
  logic check, shift_en, good;
  logic unused_edges;
  sig_sync_edge #(.sync_len(sync_len)) u_clk (
    .clk(clk_main), .rst(rst), .d(clk_data_de2), .lvl(clk_lvl), .rise(clk_rise)
  );
  sig_sync_edge #(.sync_len(sync_len)) u_latch (
    .clk(clk_main), .rst(rst), .d(latch), .lvl(latch_lvl), .rise(latch_rise)
  );
  sig_sync_edge #(.sync_len(sync_len)) u_data (
    .clk(clk_main), .rst(rst), .d(data_to_chip), .lvl(data_lvl), .rise(data_rise)
  );
  assign unused_edges = clk_lvl ^ data_rise;
  assign shift_en = clk_rise && (state != S_HOLD);
  assign cnt_next = (bit_cnt == bw'(n + 1)) ? bit_cnt : bit_cnt + 1'b1;
  assign good = bit_cnt == bw'(n);
  // latch wins over a coincident clk rise for the state, but that bit is still shifted below
  always_comb begin
    state_next = (state != S_HOLD && latch_rise) ? S_HOLD :
                 (state == S_IDLE && clk_rise)   ? S_SHIFT :
                 (state == S_HOLD && !latch_lvl) ? S_IDLE : state;
  end
  always_ff @(posedge clk_main) begin
    if (rst) begin
      state       <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      check       <= 1'b0;
      array_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      check       <= latch_rise && (state != S_HOLD);
      frame_valid <= check && good;
      frame_err   <= check && !good;
      if (check && good) begin
        array_out   <= shift_reg;
        frame_count <= frame_count + 1'b1;
      end
      if (shift_en) begin
        shift_reg <= {shift_reg[n-2:0], data_lvl};
        bit_cnt   <= cnt_next;
      end else if (state == S_HOLD && !latch_lvl) begin
        bit_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_chip_data_deser.sv
// tb_chip_data_deser: randomized frames checked against a queue-based model of the link protocol
module tb_chip_data_deser;
  localparam int N = 96;
  logic clk_main = 1'b0;
  logic rst = 1'b1;
  logic clk_data_de2 = 1'b0;
  logic data_to_chip = 1'b0;
  logic latch = 1'b0;
  logic [N-1:0] array_out;
  logic frame_valid, frame_err;
  logic [7:0] frame_count;

  chip_data_deser dut (
    .clk_main(clk_main), .rst(rst), .clk_data_de2(clk_data_de2), .data_to_chip(data_to_chip),
    .latch(latch), .array_out(array_out), .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk_main = ~clk_main;

  int n_checks = 0;
  int n_fail = 0;
  int nv = 0, ne = 0, n_both = 0;
  int dv, de, exp_v, exp_e;
  bit q[$];
  logic [N-1:0] exp_arr = '0;
  logic [7:0] exp_cnt = '0;

  always @(negedge clk_main) begin
    if (!rst) begin
      if (frame_valid) nv++;
      if (frame_err) ne++;
      if (frame_valid && frame_err) n_both++;
    end
  end

  task automatic send_bit(input bit b, input int half);
    clk_data_de2 = 1'b0;
    data_to_chip = b;
    repeat (half) @(negedge clk_main);
    clk_data_de2 = 1'b1;
    repeat (half) @(negedge clk_main);
    if (!latch) q.push_back(b);
  endtask

  task automatic send_word(input logic [N-1:0] w, input int half);
    for (int i = 0; i < N; i++) send_bit(w[N-1-i], half);
  endtask

  task automatic send_random(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom), 1);
  endtask

  task automatic latch_pulse(input int edges);
    int v0, e0;
    v0 = nv;
    e0 = ne;
    if (q.size() == N) begin
      for (int i = 0; i < N; i++) exp_arr[N-1-i] = q[i];
      exp_cnt++;
      exp_v = 1;
      exp_e = 0;
    end else begin
      exp_v = 0;
      exp_e = 1;
    end
    q.delete();
    latch = 1'b1;
    repeat (4) @(negedge clk_main);
    for (int i = 0; i < edges; i++) send_bit(1'($urandom), 1);
    latch = 1'b0;
    repeat (6) @(negedge clk_main);
    dv = nv - v0;
    de = ne - e0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      clk_data_de2 = 1'($urandom);
      data_to_chip = 1'($urandom);
      latch = 1'($urandom);
      @(negedge clk_main);
    end
    clk_data_de2 = 1'b0;
    data_to_chip = 1'b0;
    latch = 1'b0;
    @(negedge clk_main);
    rst = 1'b0;
    q.delete();
    exp_arr = '0;
    exp_cnt = '0;
    repeat (4) @(negedge clk_main);
  endtask

  task automatic test_reset();
    int v0, e0;
    do_reset();
    send_random(N);
    latch_pulse(0);
    v0 = nv;
    e0 = ne;
    do_reset();
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL reset_array: got %h want %h", array_out, exp_arr); end
    n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL reset_count: got %0d want %0d", frame_count, exp_cnt); end
    n_checks++; if ({frame_valid, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {frame_valid, frame_err}); end
    n_checks++; if (nv != v0 || ne != e0) begin n_fail++; $display("FAIL reset_no_pulse: got %0d/%0d want %0d/%0d", nv, ne, v0, e0); end
  endtask

  task automatic test_good_frame();
    send_word({12{8'hA5}}, 100);
    latch_pulse(0);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL good_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL good_array: got %h want %h", array_out, exp_arr); end
    n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL good_count: got %0d want %0d", frame_count, exp_cnt); end
  endtask

  task automatic test_short_frame();
    send_random(N - 1);
    latch_pulse(0);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL short_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL short_array: got %h want %h", array_out, exp_arr); end
    n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL short_count: got %0d want %0d", frame_count, exp_cnt); end
    send_word({N{1'b1}}, 1);
    latch_pulse(0);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL ones_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL ones_array: got %h want %h", array_out, exp_arr); end
    n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL ones_count: got %0d want %0d", frame_count, exp_cnt); end
  endtask

  task automatic test_overrun();
    send_word({N{1'b1}}, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1);
    latch_pulse(0);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL overrun_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL overrun_array: got %h want %h", array_out, exp_arr); end
  endtask

  task automatic test_latch_edges();
    send_random(N);
    latch_pulse(3);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL hold_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    send_word(96'h0123456789ABCDEF01234567, 1);
    latch_pulse(0);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL after_hold_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL after_hold_array: got %h want %h", array_out, exp_arr); end
  endtask

  task automatic test_reset_mid();
    send_random(40);
    do_reset();
    send_random(N);
    latch_pulse(0);
    n_checks++; if (dv != exp_v || de != exp_e) begin n_fail++; $display("FAIL midrst_pulses: got v%0d e%0d want v%0d e%0d", dv, de, exp_v, exp_e); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL midrst_array: got %h want %h", array_out, exp_arr); end
    n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", frame_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    int v0;
    do_reset();
    v0 = nv;
    for (int f = 0; f < 256; f++) begin
      send_random(N);
      latch_pulse(0);
      if (f == 254) begin
        n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_255: got %0d want %0d", frame_count, exp_cnt); end
      end
    end
    n_checks++; if (frame_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_zero: got %0d want %0d", frame_count, exp_cnt); end
    n_checks++; if (nv - v0 != 256) begin n_fail++; $display("FAIL wrap_valid_total: got %0d want 256", nv - v0); end
    n_checks++; if (array_out !== exp_arr) begin n_fail++; $display("FAIL wrap_array: got %h want %h", array_out, exp_arr); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_latch_edges();
    test_reset_mid();
    test_wrap();
    n_checks++; if (n_both != 0) begin n_fail++; $display("FAIL both_pulses: got %0d want 0", n_both); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
